cordic_angle_table: RTL and testbench

- Runtime-loadable, multi-channel angle table for the CORDIC datapath.
- Holds two tables selected by a mode bit:
  - mode 0: circular, arctan(2^-i)
  - mode 1: hyperbolic, atanh(2^-i)
- Tables are loaded word-by-word over a valid/ready port instead of from a file at elaboration.
- Serves N_CHANNELS independent registered read ports with valid and error flags, so several CORDIC engines can share one table.

---
 rtl/cordic_angle_table.sv | 140 ++++++++++++++
 tb/tb_cordic_angle_table.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_angle_table.sv
// Runtime-loadable circular/hyperbolic CORDIC angle table.
// Words arrive over a valid/ready load port; N_CHANNELS independent registered read ports.
module cordic_angle_table #(
  parameter int DATA_WIDTH   = 16,
  parameter int N_ITERATIONS = 15,
  parameter int N_CHANNELS   = 2,
  parameter int ADDR_WIDTH   = $clog2(N_ITERATIONS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load_start,
  input  logic                             load_mode,
  input  logic                             load_valid,
  input  logic [DATA_WIDTH-1:0]            load_data,
  output logic                             load_ready,
  output logic                             load_done,
  output logic [1:0]                       table_valid,
  input  logic [N_CHANNELS-1:0]            rd_en,
  input  logic [N_CHANNELS-1:0]            rd_mode,
  input  logic [N_CHANNELS*ADDR_WIDTH-1:0] rd_addr,
  output logic [N_CHANNELS*DATA_WIDTH-1:0] rd_data,
  output logic [N_CHANNELS-1:0]            rd_valid,
  output logic [N_CHANNELS-1:0]            rd_err
);

  localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(N_ITERATIONS - 1);
  localparam logic [ADDR_WIDTH:0]   LP_NUM  = (ADDR_WIDTH + 1)'(N_ITERATIONS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_mode;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic [1:0]              r_table_valid;
  logic                    w_wr_en;
  logic                    w_last;
  logic [N_CHANNELS-1:0]   w_legal;
  logic [DATA_WIDTH-1:0]   r_mem [2][N_ITERATIONS];

  logic [N_CHANNELS*DATA_WIDTH-1:0] r_rd_data;
  logic [N_CHANNELS-1:0]            r_rd_valid;
  logic [N_CHANNELS-1:0]            r_rd_err;

  assign w_last      = (r_cnt == LP_LAST);
  assign table_valid = r_table_valid;
  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign rd_err      = r_rd_err;

  always_comb begin
    w_next     = r_state;
    load_ready = 1'b0;
    load_done  = 1'b0;
    w_wr_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load_start) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        load_ready = 1'b1;
        w_wr_en    = load_valid & ~rst;
        if (load_valid && w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        load_done = 1'b1;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // The valid bit is set on the edge leaving DONE, so a read issued in DONE still errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_mode        <= 1'b0;
      r_cnt         <= '0;
      r_table_valid <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (load_start) begin
            r_mode                   <= load_mode;
            r_cnt                    <= '0;
            r_table_valid[load_mode] <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (w_wr_en) r_cnt <= r_cnt + 1'b1;
        end
        ST_DONE: r_table_valid[r_mode] <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_mode][r_cnt] <= load_data;
  end

  always_comb begin
    w_legal = '0;
    for (int unsigned k = 0; k < N_CHANNELS; k++) begin
      w_legal[k] = ({1'b0, rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]} < LP_NUM)
                   && r_table_valid[rd_mode[k]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= '0;
      r_rd_err   <= '0;
    end else begin
      for (int unsigned k = 0; k < N_CHANNELS; k++) begin
        if (rd_en[k]) begin
          r_rd_valid[k] <= 1'b1;
          if (w_legal[k]) begin
            r_rd_data[k*DATA_WIDTH +: DATA_WIDTH] <=
              r_mem[rd_mode[k]][rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
            r_rd_err[k] <= 1'b0;
          end else begin
            r_rd_data[k*DATA_WIDTH +: DATA_WIDTH] <= '0;
            r_rd_err[k] <= 1'b1;
          end
        end else begin
          r_rd_valid[k] <= 1'b0;
          r_rd_err[k]   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cordic_angle_table.sv
// Scoreboard bench for cordic_angle_table: a reference model predicts read results
// and load handshake outputs cycle by cycle.
module tb_cordic_angle_table;

  localparam int DW = 16;
  localparam int NI = 15;
  localparam int NC = 2;
  localparam int AW = $clog2(NI);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              load_start = 1'b0;
  logic              load_mode = 1'b0;
  logic              load_valid = 1'b0;
  logic [DW-1:0]     load_data = '0;
  logic              load_ready;
  logic              load_done;
  logic [1:0]        table_valid;
  logic [NC-1:0]     rd_en = '0;
  logic [NC-1:0]     rd_mode = '0;
  logic [NC*AW-1:0]  rd_addr = '0;
  logic [NC*DW-1:0]  rd_data;
  logic [NC-1:0]     rd_valid;
  logic [NC-1:0]     rd_err;

  cordic_angle_table #(
    .DATA_WIDTH  (DW),
    .N_ITERATIONS(NI),
    .N_CHANNELS  (NC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_mode  (load_mode),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done),
    .table_valid(table_valid),
    .rd_en      (rd_en),
    .rd_mode    (rd_mode),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_err     (rd_err)
  );

  typedef struct {
    int            ch;
    logic          v;
    logic          e;
    logic [DW-1:0] d;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int failed = 0;

  // Reference model: 0 = idle, 1 = loading, 2 = done
  int            m_state = 0;
  bit            m_mode = 1'b0;
  int            m_cnt = 0;
  logic [1:0]    m_tv = 2'b00;
  logic [DW-1:0] m_mem [2][NI];
  logic [DW-1:0] m_hold [NC];
  int            ready_cnt = 0;
  int            done_cnt = 0;
  logic [DW-1:0] tbl0 [NI];
  logic [DW-1:0] tbl1 [NI];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic set_rd(input int ch, input bit en, input bit md, input int a);
    rd_en[ch] = en;
    rd_mode[ch] = md;
    rd_addr[ch*AW +: AW] = a[AW-1:0];
  endtask

  task automatic tick();
    exp_t e;
    for (int k = 0; k < NC; k++) begin
      int a;
      bit md;
      a = int'(rd_addr[k*AW +: AW]);
      md = rd_mode[k];
      e.ch = k;
      if (rd_en[k]) begin
        e.v = 1'b1;
        if (a < NI && m_tv[md]) begin
          e.e = 1'b0;
          e.d = m_mem[md][a];
        end else begin
          e.e = 1'b1;
          e.d = '0;
        end
        m_hold[k] = e.d;
      end else begin
        e.v = 1'b0;
        e.e = 1'b0;
        e.d = m_hold[k];
      end
      sb.push_back(e);
    end
    case (m_state)
      0: if (load_start) begin
        m_mode = load_mode;
        m_tv[load_mode] = 1'b0;
        m_cnt = 0;
        m_state = 1;
      end
      1: if (load_valid) begin
        m_mem[m_mode][m_cnt] = load_data;
        if (m_cnt == NI - 1) m_state = 2;
        m_cnt++;
      end
      default: begin
        m_tv[m_mode] = 1'b1;
        m_state = 0;
      end
    endcase
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("rd_valid[%0d]", e.ch), rd_valid[e.ch], e.v);
      check($sformatf("rd_err[%0d]", e.ch), rd_err[e.ch], e.e);
      check($sformatf("rd_data[%0d]", e.ch), rd_data[e.ch*DW +: DW], e.d);
    end
    check("load_ready", load_ready, m_state == 1);
    check("load_done", load_done, m_state == 2);
    check("table_valid", table_valid, m_tv);
    if (load_ready) ready_cnt++;
    if (load_done) done_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_state = 0;
    m_cnt = 0;
    m_tv = 2'b00;
    for (int k = 0; k < NC; k++) m_hold[k] = '0;
    check("rst_load_ready", load_ready, 1'b0);
    check("rst_load_done", load_done, 1'b0);
    check("rst_table_valid", table_valid, 2'b00);
    check("rst_rd_valid", rd_valid, '0);
    check("rst_rd_err", rd_err, '0);
    check("rst_rd_data", rd_data, '0);
  endtask

  task automatic load_table(input bit md, input bit toggle, input bit inject, input bit rdscan);
    int wi = 0;
    int cyc = 0;
    ready_cnt = 0;
    done_cnt = 0;
    load_start = 1'b1;
    load_mode = md;
    tick();
    load_start = 1'b0;
    while (m_state != 0 && cyc < 100) begin
      load_valid = toggle ? cyc[0] : 1'b1;
      load_data = md ? tbl1[wi % NI] : tbl0[wi % NI];
      if (inject && cyc == 3) begin
        load_start = 1'b1;
        load_mode = ~md;
      end else begin
        load_start = 1'b0;
      end
      if (rdscan) begin
        set_rd(0, 1'b1, 1'b0, cyc % 16);
        set_rd(1, 1'b1, 1'b1, cyc % 16);
      end
      if (m_state == 1 && load_valid) wi++;
      tick();
      cyc++;
    end
    load_valid = 1'b0;
    load_start = 1'b0;
    rd_en = '0;
    check("load_bound", cyc < 100, 1'b1);
    check("words_accepted", wi, NI);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl0[0] = 16'h1922;
    tbl0[1] = 16'h0ED6;
    for (int i = 2; i < NI; i++) tbl0[i] = DW'(16'h07D7 >> (i - 2));
    for (int i = 0; i < NI; i++) tbl1[i] = 16'h8000 ^ DW'(i * 16'h1357);
    for (int k = 0; k < NC; k++) m_hold[k] = '0;

    repeat (2) @(posedge clk);
    do_reset();

    // Mode 0 load, valid held high
    load_table(1'b0, 1'b0, 1'b0, 1'b0);
    check("m0_ready_cycles", ready_cnt, 15);
    check("m0_done_pulses", done_cnt, 1);
    check("m0_table_valid", table_valid, 2'b01);

    // Two channels, different entries, same cycle
    set_rd(0, 1'b1, 1'b0, 1);
    set_rd(1, 1'b1, 1'b0, 0);
    tick();
    check("ch0_addr1", rd_data[DW-1:0], 16'h0ED6);
    check("ch1_addr0", rd_data[2*DW-1:DW], 16'h1922);
    check("dual_valid", rd_valid, 2'b11);
    check("dual_err", rd_err, 2'b00);
    rd_en = '0;
    tick();
    check("hold_ch0", rd_data[DW-1:0], 16'h0ED6);

    // Out-of-range address and unloaded table
    set_rd(0, 1'b1, 1'b0, 15);
    set_rd(1, 1'b1, 1'b1, 3);
    tick();
    check("illegal_valid", rd_valid, 2'b11);
    check("illegal_err", rd_err, 2'b11);
    check("illegal_data", rd_data, '0);
    rd_en = '0;
    tick();

    // Mode 1 load with stalls while both tables are read
    load_table(1'b1, 1'b1, 1'b0, 1'b1);
    check("m1_table_valid", table_valid, 2'b11);
    check("m1_done_pulses", done_cnt, 1);

    // Reset after word 7 of a mode 0 reload
    load_start = 1'b1;
    load_mode = 1'b0;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      load_data = tbl0[i] ^ 16'h00FF;
      tick();
    end
    load_valid = 1'b0;
    set_rd(0, 1'b1, 1'b1, 2);
    set_rd(1, 1'b1, 1'b1, 5);
    do_reset();
    rd_en = '0;
    set_rd(0, 1'b1, 1'b0, 1);
    tick();
    check("post_rst_err", rd_err[0], 1'b1);
    check("post_rst_data", rd_data[DW-1:0], 16'h0000);
    rd_en = '0;
    tick();

    // load_start with opposite mode during LOAD is ignored
    load_table(1'b1, 1'b0, 1'b1, 1'b1);
    check("inj_table_valid", table_valid, 2'b10);
    check("inj_ready_cycles", ready_cnt, 15);
    check("inj_done_pulses", done_cnt, 1);
    set_rd(0, 1'b1, 1'b0, 0);
    set_rd(1, 1'b1, 1'b1, 14);
    tick();
    check("inj_err", rd_err, 2'b01);
    check("inj_ch1_data", rd_data[2*DW-1:DW], tbl1[14]);
    rd_en = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
